// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic DIR_LOAD  = 1'b1;

endpackage

// File: rtl/ram256x8.sv
// Single-port byte array: synchronous write, combinational read.
module ram256x8 #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [7:0]            wdata_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[addr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory responder: serializes big-endian word accesses one byte per cycle
// over a byte array and stalls the pipeline until the access completes.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  MEM_load_store_instr,
    input  logic                  MEM_load_instr,
    input  logic                  MEM_size,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  Busy,
    output logic                  Done
);

    state_e                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    load_q, load_d;
    logic                    size_q, size_d;
    logic [31:0]             asm_q, asm_d;
    logic [31:0]             dout_q, dout_d;
    logic                    done_q, done_d;

    logic [ADDR_WIDTH-1:0]   byte_addr;
    logic [7:0]              rd_byte;
    logic [7:0]              wr_byte;
    logic                    we;

    assign byte_addr = addr_q + ADDR_WIDTH'(cnt_q);
    assign we        = (state_q == XFER) && (load_q != DIR_LOAD);

    // Big-endian: byte 0 of the word is DataIn[31:24].
    always_comb begin
        wr_byte = wdata_q[7:0];
        if (size_q == SIZE_WORD) begin
            unique case (cnt_q)
                2'd0:    wr_byte = wdata_q[31:24];
                2'd1:    wr_byte = wdata_q[23:16];
                2'd2:    wr_byte = wdata_q[15:8];
                default: wr_byte = wdata_q[7:0];
            endcase
        end
    end

    ram256x8 #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (we),
        .addr_i  (byte_addr),
        .wdata_i (wr_byte),
        .rdata_o (rd_byte)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        size_d  = size_q;
        asm_d   = asm_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MEM_load_store_instr) begin
                    addr_d  = Address;
                    if (MEM_size == SIZE_WORD) begin
                        addr_d[1:0] = 2'b00;
                    end
                    wdata_d = DataIn;
                    load_d  = MEM_load_instr;
                    size_d  = MEM_size;
                    cnt_d   = 2'd0;
                    state_d = XFER;
                end
            end
            XFER: begin
                asm_d = (size_q == SIZE_BYTE) ? {24'h0, rd_byte} : {asm_q[23:0], rd_byte};
                if ((size_q == SIZE_BYTE) || (cnt_q == 2'd3)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    // Register the result on the last byte so it is valid throughout DONE.
                    if (load_q == DIR_LOAD) begin
                        dout_d = asm_d;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            load_q  <= 1'b0;
            size_q  <= SIZE_WORD;
            asm_q   <= 32'h0;
            dout_q  <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            size_q  <= size_d;
            asm_q   <= asm_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign DataOut = dout_q;
    assign Done    = done_q;
    assign Busy    = (state_q == XFER) || ((state_q == IDLE) && MEM_load_store_instr);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl.
module tb_data_mem_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req;
    logic        ld;
    logic        sz;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] DataOut;
    logic        Busy;
    logic        Done;

    int checks = 0;
    int errors = 0;

    data_mem_ctrl #(
        .ADDR_WIDTH (8),
        .DEPTH      (256)
    ) dut (
        .Clk                  (Clk),
        .Reset                (Reset),
        .MEM_load_store_instr (req),
        .MEM_load_instr       (ld),
        .MEM_size             (sz),
        .Address              (addr),
        .DataIn               (din),
        .DataOut              (DataOut),
        .Busy                 (Busy),
        .Done                 (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call #1 after a posedge with the DUT in IDLE; returns with the DUT back in IDLE.
    // lat counts cycles from the request cycle (0) to the Done cycle; -1 if Done never came.
    task automatic access(input logic l, input logic s, input logic [7:0] a,
                          input logic [31:0] d, output int lat, output int busy_cnt);
        req = 1'b1; ld = l; sz = s; addr = a; din = d;
        lat = -1;
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = c;
                break;
            end
            @(posedge Clk);
            #1;
            req = 1'b0;
        end
        req = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    int lat;
    int bcnt;
    logic exp_done;

    initial begin
        Reset = 1'b0; req = 1'b1; ld = 1'b0; sz = 1'b0; addr = 8'h00; din = 32'h0;

        // Reset held with request asserted
        @(negedge Clk);
        @(negedge Clk);
        check("rst_dataout", DataOut, 32'h0);
        check("rst_done", {31'h0, Done}, 32'h0);
        check("rst_state", {30'h0, dut.state_q}, 32'h0);
        check("rst_cnt", {30'h0, dut.cnt_q}, 32'h0);
        req = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        check("idle_busy_noreq", {31'h0, Busy}, 32'h0);
        req = 1'b1;
        #1;
        check("idle_busy_req", {31'h0, Busy}, 32'h1);
        req = 1'b0;
        @(posedge Clk);
        #1;
        check("idle_stays", {30'h0, dut.state_q}, 32'h0);

        for (int i = 0; i < 256; i++) dut.u_ram.mem[i] = 8'h00;
        dut.u_ram.mem[8'h22] = 8'h55;
        dut.u_ram.mem[8'h23] = 8'h66;

        // Word store then aligned word load
        access(1'b0, 1'b0, 8'h10, 32'hDEADBEEF, lat, bcnt);
        check("wst_lat", lat, 32'd5);
        check("wst_busy", bcnt, 32'd5);
        check("wst_m10", {24'h0, dut.u_ram.mem[8'h10]}, 32'hDE);
        check("wst_m11", {24'h0, dut.u_ram.mem[8'h11]}, 32'hAD);
        check("wst_m12", {24'h0, dut.u_ram.mem[8'h12]}, 32'hBE);
        check("wst_m13", {24'h0, dut.u_ram.mem[8'h13]}, 32'hEF);
        check("wst_dout", DataOut, 32'h0);
        access(1'b1, 1'b0, 8'h12, 32'h0, lat, bcnt);
        check("wld_lat", lat, 32'd5);
        check("wld_dout", DataOut, 32'hDEADBEEF);

        // Byte store/load at the top address
        access(1'b0, 1'b1, 8'hFF, 32'h12345678, lat, bcnt);
        check("bst_lat", lat, 32'd2);
        check("bst_busy", bcnt, 32'd2);
        check("bst_mff", {24'h0, dut.u_ram.mem[8'hFF]}, 32'h78);
        check("bst_m00", {24'h0, dut.u_ram.mem[8'h00]}, 32'h00);
        access(1'b1, 1'b1, 8'hFF, 32'h0, lat, bcnt);
        check("bld_lat", lat, 32'd2);
        check("bld_dout", DataOut, 32'h00000078);

        // Store leaves DataOut untouched
        access(1'b1, 1'b0, 8'h10, 32'h0, lat, bcnt);
        check("reld_dout", DataOut, 32'hDEADBEEF);
        access(1'b0, 1'b0, 8'h10, 32'h0, lat, bcnt);
        check("st0_dout", DataOut, 32'hDEADBEEF);
        check("st0_m10", {24'h0, dut.u_ram.mem[8'h10]}, 32'h00);
        check("st0_m13", {24'h0, dut.u_ram.mem[8'h13]}, 32'h00);

        // Back-to-back byte loads: IDLE, XFER, DONE repeating
        req = 1'b1; ld = 1'b1; sz = 1'b1; addr = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clk);
            exp_done = ((i % 3) == 2);
            check("b2b_done", {31'h0, Done}, {31'h0, exp_done});
            check("b2b_busy", {31'h0, Busy}, {31'h0, !exp_done});
        end
        req = 1'b0;
        @(posedge Clk);
        #1;
        check("b2b_dout", DataOut, 32'h00000078);

        // Reset during the third XFER cycle of a word store
        req = 1'b1; ld = 1'b0; sz = 1'b0; addr = 8'h20; din = 32'hAABBCCDD;
        @(posedge Clk);
        #1;
        req = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check("rms_cnt", {30'h0, dut.cnt_q}, 32'd2);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("rms_state", {30'h0, dut.state_q}, 32'h0);
        check("rms_dout", DataOut, 32'h0);
        @(posedge Clk);
        #1;
        check("rms_m20", {24'h0, dut.u_ram.mem[8'h20]}, 32'hAA);
        check("rms_m21", {24'h0, dut.u_ram.mem[8'h21]}, 32'hBB);
        check("rms_m22", {24'h0, dut.u_ram.mem[8'h22]}, 32'h55);
        check("rms_m23", {24'h0, dut.u_ram.mem[8'h23]}, 32'h66);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rms_nodone", {31'h0, Done}, 32'h0);
        end
        check("rms_m22_late", {24'h0, dut.u_ram.mem[8'h22]}, 32'h55);
        check("rms_m23_late", {24'h0, dut.u_ram.mem[8'h23]}, 32'h66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
